// File: rtl/id_ex_stage_if.sv
// Bundle of ID-stage operands/control, forwarding sources and EX-stage outputs
// exchanged with the ID/EX pipeline register.
interface id_ex_stage_if #(
  parameter int W  = 32,
  parameter int RA = 5
);
  logic          hold;
  logic          flush;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic [RA-1:0] id_rs;
  logic [RA-1:0] id_rt;
  logic [RA-1:0] id_rd;
  logic [5:0]    id_funct;
  logic [1:0]    id_aluop;
  logic          id_alusrc;
  logic          id_regdst;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_regwrite;
  logic          id_memtoreg;
  logic          exmem_regwrite;
  logic [RA-1:0] exmem_rd;
  logic [W-1:0]  exmem_result;
  logic          memwb_regwrite;
  logic [RA-1:0] memwb_rd;
  logic [W-1:0]  memwb_result;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [2:0]    ex_sel;
  logic [W-1:0]  ex_store_data;
  logic [RA-1:0] ex_wreg;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_regwrite;
  logic          ex_memtoreg;
  logic          ex_illegal;
  logic          stall_id;

  modport master (
    output hold, flush, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_funct, id_aluop, id_alusrc, id_regdst, id_memread, id_memwrite,
           id_regwrite, id_memtoreg, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  ex_a, ex_b, ex_sel, ex_store_data, ex_wreg, ex_memread, ex_memwrite,
           ex_regwrite, ex_memtoreg, ex_illegal, stall_id
  );

  modport slave (
    input  hold, flush, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_funct, id_aluop, id_alusrc, id_regdst, id_memread, id_memwrite,
           id_regwrite, id_memtoreg, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output ex_a, ex_b, ex_sel, ex_store_data, ex_wreg, ex_memread, ex_memwrite,
           ex_regwrite, ex_memtoreg, ex_illegal, stall_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU-select decode at capture, EX/MEM and MEM/WB
// operand forwarding on the stored operands, and load-use stall generation.
module id_ex_stage #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic [W-1:0]  rs_data_q, rt_data_q, imm_q;
  logic [RA-1:0] rs_q, rt_q, wreg_q;
  logic [2:0]    sel_q;
  logic          alusrc_q, memread_q, memwrite_q, regwrite_q, memtoreg_q, illegal_q;

  logic [2:0]    dec_sel;
  logic          dec_illegal;
  logic          load_use;
  logic [W-1:0]  fwd_rs, fwd_rt;

  always_comb begin
    dec_sel     = 3'b010;
    dec_illegal = 1'b0;
    case (bus.id_aluop)
      2'b00: dec_sel = 3'b010;
      2'b01: dec_sel = 3'b110;
      2'b11: dec_sel = 3'b001;
      default: begin
        case (bus.id_funct)
          6'b100100: dec_sel = 3'b000;
          6'b100101: dec_sel = 3'b001;
          6'b100000: dec_sel = 3'b010;
          6'b100010: dec_sel = 3'b110;
          6'b101010: dec_sel = 3'b111;
          default: begin
            dec_sel     = 3'b010;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Conservative: rt is compared even when the ID op only reads rs.
  assign load_use = memread_q && (wreg_q != '0) &&
                    ((wreg_q == bus.id_rs) || (wreg_q == bus.id_rt));
  assign bus.stall_id = load_use && !bus.hold && !bus.flush;

  // A flush coinciding with load-use still costs only one bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      sel_q      <= '0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!bus.hold) begin
      if (bus.flush || load_use) begin
        rs_data_q  <= '0;
        rt_data_q  <= '0;
        imm_q      <= '0;
        rs_q       <= '0;
        rt_q       <= '0;
        wreg_q     <= '0;
        sel_q      <= '0;
        alusrc_q   <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        illegal_q  <= 1'b0;
      end else begin
        rs_data_q  <= bus.id_rs_data;
        rt_data_q  <= bus.id_rt_data;
        imm_q      <= bus.id_imm;
        rs_q       <= bus.id_rs;
        rt_q       <= bus.id_rt;
        wreg_q     <= bus.id_regdst ? bus.id_rd : bus.id_rt;
        sel_q      <= dec_sel;
        alusrc_q   <= bus.id_alusrc;
        memread_q  <= bus.id_memread;
        memwrite_q <= bus.id_memwrite;
        regwrite_q <= bus.id_regwrite && !dec_illegal;
        memtoreg_q <= bus.id_memtoreg;
        illegal_q  <= dec_illegal;
      end
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_q))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_q))
      fwd_rs = bus.memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_q))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_q))
      fwd_rt = bus.memwb_result;
  end

  assign bus.ex_a          = fwd_rs;
  assign bus.ex_b          = alusrc_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_sel        = sel_q;
  assign bus.ex_wreg       = wreg_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memtoreg   = memtoreg_q;
  assign bus.ex_illegal    = illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage, checked against a
// transaction-level model of what EX should hold after each edge.
module tb_id_ex_stage;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  id_ex_stage_if #(.W(32), .RA(5)) bus ();

  id_ex_stage #(.W(32), .RA(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [2:0]  sel;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        illegal;
  } ex_t;

  ex_t model;

  logic [5:0] legal_funct [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
  logic [2:0] legal_sel   [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  function automatic ex_t captureModel();
    ex_t n;
    logic hit;
    n   = '0;
    hit = 1'b0;
    n.rs_data  = bus.id_rs_data;
    n.rt_data  = bus.id_rt_data;
    n.imm      = bus.id_imm;
    n.rs       = bus.id_rs;
    n.rt       = bus.id_rt;
    n.wreg     = bus.id_regdst ? bus.id_rd : bus.id_rt;
    n.alusrc   = bus.id_alusrc;
    n.memread  = bus.id_memread;
    n.memwrite = bus.id_memwrite;
    n.regwrite = bus.id_regwrite;
    n.memtoreg = bus.id_memtoreg;
    if (bus.id_aluop == 2'b00) n.sel = 3'b010;
    else if (bus.id_aluop == 2'b01) n.sel = 3'b110;
    else if (bus.id_aluop == 2'b11) n.sel = 3'b001;
    else begin
      for (int i = 0; i < 5; i++)
        if (legal_funct[i] == bus.id_funct) begin
          n.sel = legal_sel[i];
          hit   = 1'b1;
        end
      if (!hit) begin
        n.sel      = 3'b010;
        n.illegal  = 1'b1;
        n.regwrite = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic modelLoadUse();
    return model.memread && model.wreg != 0 &&
           (model.wreg == bus.id_rs || model.wreg == bus.id_rt);
  endfunction

  function automatic logic [31:0] modelFwd(input logic [4:0] r, input logic [31:0] d);
    if (bus.exmem_regwrite && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_result;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] rt_fwd;
    rt_fwd = modelFwd(model.rt, model.rt_data);
    chk({tag, ".ex_a"}, bus.ex_a, modelFwd(model.rs, model.rs_data));
    chk({tag, ".ex_b"}, bus.ex_b, model.alusrc ? model.imm : rt_fwd);
    chk({tag, ".ex_store_data"}, bus.ex_store_data, rt_fwd);
    chk({tag, ".ex_sel"}, 32'(bus.ex_sel), 32'(model.sel));
    chk({tag, ".ex_wreg"}, 32'(bus.ex_wreg), 32'(model.wreg));
    chk({tag, ".ex_memread"}, 32'(bus.ex_memread), 32'(model.memread));
    chk({tag, ".ex_memwrite"}, 32'(bus.ex_memwrite), 32'(model.memwrite));
    chk({tag, ".ex_regwrite"}, 32'(bus.ex_regwrite), 32'(model.regwrite));
    chk({tag, ".ex_memtoreg"}, 32'(bus.ex_memtoreg), 32'(model.memtoreg));
    chk({tag, ".ex_illegal"}, 32'(bus.ex_illegal), 32'(model.illegal));
    chk({tag, ".stall_id"}, 32'(bus.stall_id),
        32'(modelLoadUse() && !bus.hold && !bus.flush));
  endtask

  // Advance one edge; the model's next EX content is decided from pre-edge inputs.
  task automatic clockEdge();
    ex_t nxt;
    if (bus.hold) nxt = model;
    else if (bus.flush || modelLoadUse()) nxt = '0;
    else nxt = captureModel();
    @(posedge clk);
    #1;
    model = nxt;
  endtask

  task automatic setOp(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic alusrc, input logic regdst, input logic memread,
                       input logic memwrite, input logic regwrite, input logic memtoreg);
    bus.id_aluop    = aluop;
    bus.id_funct    = funct;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_rs_data  = rsd;
    bus.id_rt_data  = rtd;
    bus.id_imm      = imm;
    bus.id_alusrc   = alusrc;
    bus.id_regdst   = regdst;
    bus.id_memread  = memread;
    bus.id_memwrite = memwrite;
    bus.id_regwrite = regwrite;
    bus.id_memtoreg = memtoreg;
  endtask

  task automatic clearFwd();
    bus.exmem_regwrite = 1'b0;
    bus.exmem_rd       = '0;
    bus.exmem_result   = '0;
    bus.memwb_regwrite = 1'b0;
    bus.memwb_rd       = '0;
    bus.memwb_result   = '0;
  endtask

  task automatic applyStimulus();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    setOp(2'($urandom), ($urandom_range(0, 4) != 0) ? legal_funct[$urandom_range(0, 4)] : 6'($urandom),
          rs, rt, rd, $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    bus.hold           = ($urandom_range(0, 9) == 0);
    bus.flush          = ($urandom_range(0, 9) == 0);
    bus.exmem_regwrite = 1'($urandom);
    bus.exmem_rd       = 5'($urandom_range(0, 3));
    bus.exmem_result   = $urandom;
    bus.memwb_regwrite = 1'($urandom);
    bus.memwb_rd       = 5'($urandom_range(0, 3));
    bus.memwb_result   = $urandom;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model  = '0;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    clearFwd();
    setOp(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #12;
    checkOutput("reset0");
    reset = 1'b1;
    @(negedge clk);

    // SLT and illegal funct.
    setOp(2'b10, 6'b101010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'h40, 0, 1, 0, 0, 1, 0);
    clockEdge();
    setOp(2'b10, 6'b000111, 5'd4, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0, 0, 1, 0, 0, 1, 0);
    #1;
    checkOutput("slt");
    chk("slt.sel_const", 32'(bus.ex_sel), 32'd7);
    chk("slt.a_const", bus.ex_a, 32'd5);
    chk("slt.b_const", bus.ex_b, 32'd9);
    clockEdge();
    checkOutput("illegal");
    chk("illegal.flag_const", 32'(bus.ex_illegal), 32'd1);
    chk("illegal.regwrite_const", 32'(bus.ex_regwrite), 32'd0);

    // Forwarding priority on rs=8.
    setOp(2'b00, 6'd0, 5'd8, 5'd2, 5'd0, 32'h1234, 32'h5, 32'h0, 0, 0, 0, 0, 1, 0);
    clockEdge();
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'hAAAA;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'hBBBB;
    #1;
    checkOutput("fwd_both");
    chk("fwd_both.a_const", bus.ex_a, 32'hAAAA);
    bus.exmem_rd = 5'd0;
    #1;
    checkOutput("fwd_memwb");
    chk("fwd_memwb.a_const", bus.ex_a, 32'hBBBB);
    clearFwd();

    // Load-use on $9, then a load to $0 that must not stall.
    setOp(2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 0, 1, 1);
    clockEdge();
    setOp(2'b00, 6'd0, 5'd9, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 0, 1, 0, 0, 1, 0);
    #1;
    checkOutput("lu_stall");
    chk("lu_stall.const", 32'(bus.stall_id), 32'd1);
    clockEdge();
    checkOutput("lu_bubble");
    chk("lu_bubble.regwrite_const", 32'(bus.ex_regwrite), 32'd0);
    chk("lu_bubble.stall_const", 32'(bus.stall_id), 32'd0);
    setOp(2'b00, 6'd0, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 0, 1, 1);
    clockEdge();
    setOp(2'b00, 6'd0, 5'd0, 5'd0, 5'd3, 32'h7, 32'h8, 32'h0, 0, 1, 0, 0, 1, 0);
    #1;
    checkOutput("lu_r0");
    chk("lu_r0.stall_const", 32'(bus.stall_id), 32'd0);

    // Flush of a valid add, then flush coinciding with load-use.
    bus.flush = 1'b1;
    clockEdge();
    checkOutput("flush");
    chk("flush.regwrite_const", 32'(bus.ex_regwrite), 32'd0);
    bus.flush = 1'b0;
    setOp(2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 0, 1, 1);
    clockEdge();
    setOp(2'b00, 6'd0, 5'd9, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 0, 1, 0, 0, 1, 0);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_lu");
    chk("flush_lu.stall_const", 32'(bus.stall_id), 32'd0);
    clockEdge();
    bus.flush = 1'b0;
    #1;
    checkOutput("flush_lu_bubble");
    clockEdge();
    checkOutput("flush_lu_after");
    chk("flush_lu_after.a_const", bus.ex_a, 32'h7);

    // Hold three cycles with a load in EX and a conflicting ID op.
    setOp(2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 0, 1, 1);
    clockEdge();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setOp(2'b01, 6'd0, 5'd9, 5'($urandom_range(0, 31)), 5'd3, $urandom, $urandom, $urandom,
            0, 1, 0, 0, 1, 0);
      #1;
      checkOutput("hold");
      chk("hold.wreg_const", 32'(bus.ex_wreg), 32'd9);
      chk("hold.stall_const", 32'(bus.stall_id), 32'd0);
      clockEdge();
    end
    bus.hold = 1'b0;
    setOp(2'b00, 6'd0, 5'd2, 5'd3, 5'd4, 32'h77, 32'h1, 32'h0, 0, 1, 0, 0, 1, 0);
    clockEdge();
    checkOutput("hold_release");
    chk("hold_release.a_const", bus.ex_a, 32'h77);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus();
      #1;
      checkOutput("rand");
      clockEdge();
    end
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    clearFwd();

    // Asynchronous reset in the middle of a cycle with a load in EX.
    setOp(2'b00, 6'd0, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 0, 1, 1);
    clockEdge();
    setOp(2'b00, 6'd0, 5'd9, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 0, 1, 0, 0, 1, 0);
    #1;
    checkOutput("pre_reset");
    #2;
    reset = 1'b0;
    model = '0;
    #1;
    checkOutput("async_reset");
    chk("async_reset.stall_const", 32'(bus.stall_id), 32'd0);
    chk("async_reset.memread_const", 32'(bus.ex_memread), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    setOp(2'b00, 6'd0, 5'd2, 5'd3, 5'd4, 32'h55, 32'h66, 32'h0, 0, 1, 0, 0, 1, 0);
    #1;
    checkOutput("reset_release");
    clockEdge();
    checkOutput("first_after_reset");
    chk("first_after_reset.a_const", bus.ex_a, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
